program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
Boot-time writer for the processor's instruction memory. It receives a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It drives a word-write port into instruction memory and holds the processor in reset until the image is loaded and its checksum verifies.

Parameters:
MAX_WORDS, 18, maximum words accepted (instruction memory depth)
BASE_ADDR, 32'h0000_0000, byte address of the first word written
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  byte present on in_data
in_data  input  8  stream byte
in_ready  output  1  loader can accept a byte; a transfer occurs on a clk edge with in_valid&&in_ready
imem_we  output  1  one-cycle instruction-memory write strobe
imem_addr  output  32  byte address of the write; word aligned
imem_wdata  output  32  word to write
cpu_hold  output  1  holds the processor (PC/regfile) in reset while high
done  output  1  image loaded and checksum OK; sticky
error  output  1  frame rejected; sticky
words_loaded  output  16  count of words written so far

Behaviour:
- Reset (reset=0, async) values: in_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0, state=IDLE. Asserting reset mid-frame aborts the frame and applies the same values; already-written words are not undone.
- Frame format: SYNC, CNT_HI, CNT_LO, then N=count words of 4 bytes each (MSB first), then CHK. CHK is the XOR of every byte from CNT_HI through the last data byte; SYNC is excluded.
- States: IDLE, CNT_HI, CNT_LO, DATA, CHECK, DONE, ERR. in_ready=1 in IDLE, CNT_HI, CNT_LO, DATA and CHECK, and 0 in DONE and ERR. in_ready is registered and rises the first cycle after reset is released.
- IDLE: every accepted byte is consumed. A byte equal to SYNC_BYTE moves to CNT_HI and clears the checksum accumulator. Any other byte is discarded and the state stays IDLE.
- CNT_HI / CNT_LO: each byte is latched into a 16-bit count and XORed into the accumulator.
- Decision after CNT_LO is accepted:
  - count > MAX_WORDS -> ERR on the next edge.
  - count == 0 -> CHECK.
  - otherwise -> DATA with byte index 0 and word index 0.
- DATA: byte k (0..3) goes to shift-register bits [31-8k -: 8] and is XORed into the accumulator. When byte 3 is accepted at edge E, the cycle after E shows:
  - imem_we=1 for exactly one cycle;
  - imem_wdata = the assembled word;
  - imem_addr = BASE_ADDR + 4*word_index (32-bit wraparound arithmetic);
  - words_loaded incremented.
  After the last word the next state is CHECK; otherwise DATA continues with the next word.
- Back-to-back bytes (in_valid held high) must be accepted every cycle with no bubbles. The write strobe overlaps acceptance of the next word's byte 0.
- CHECK: the accepted byte is compared with the accumulator. Match -> DONE: done=1 and cpu_hold=0 from the cycle after the acceptance edge. Mismatch -> ERR: error=1 and cpu_hold stays 1.
- DONE and ERR are terminal until reset. Further in_valid is ignored because in_ready=0.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- done and error are never both 1.

Test Plan:
- Good 2-word load, back-to-back: A5 00 02 20 08 00 05 20 09 00 0A 0C -> imem_we pulses twice with (addr 0x0, data 0x20080005) and (addr 0x4, data 0x2009000A); words_loaded=2; done=1 and cpu_hold=0 one cycle after the 0x0C is accepted; error=0.
- Same frame with checksum 0x0D -> both writes still occur; error=1, done=0, cpu_hold=1, in_ready=0 thereafter.
- Leading junk and throttling: 00 FF 3C then the frame from the first case, with in_valid low for 2 cycles between every byte -> junk is ignored, identical writes, done=1.
- Oversize count (MAX_WORDS=18): A5 00 13 -> error=1 the cycle after 0x13 is accepted; no imem_we pulse; in_ready=0.
- Empty image: A5 00 00 00 -> no writes, words_loaded=0, done=1, cpu_hold=0.
- Reset mid-frame: drive reset=0 asynchronously after A5 00 02 20 08, then re-send the full good frame -> outputs return immediately to reset values; the reload completes with done=1 and two correct writes.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time instruction-memory loader: parses a framed byte stream into
// big-endian words, writes them out, and releases the CPU once the checksum matches.
module program_loader #(
    parameter int          MAX_WORDS = 18,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded,
    output logic [2:0]  state
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CNT_HI = 3'd1;
    localparam logic [2:0] CNT_LO = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] CHECK  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;

    localparam logic [15:0] MAX_COUNT = 16'(MAX_WORDS);

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
    logic        accept;
    logic [2:0]  state_next;
    logic [15:0] count;
    logic [15:0] full_count;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [7:0]  chk;
    logic [23:0] shreg;

    assign accept     = in_valid && in_ready;
    assign full_count = {count[15:8], in_data};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (accept && in_data == SYNC_BYTE) state_next = CNT_HI;
            CNT_HI: if (accept) state_next = CNT_LO;
            CNT_LO: begin
                if (accept) begin
                    if (full_count > MAX_COUNT)  state_next = ERR;
                    else if (full_count == 16'd0) state_next = CHECK;
                    else                          state_next = DATA;
                end
            end
            DATA: begin
                if (accept && byte_idx == 2'd3 && (word_idx + 16'd1) == count)
                    state_next = CHECK;
            end
            CHECK:  if (accept) state_next = (in_data == chk) ? DONE : ERR;
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= BASE_ADDR;
            imem_wdata   <= 32'd0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
            count        <= 16'd0;
            word_idx     <= 16'd0;
            byte_idx     <= 2'd0;
            chk          <= 8'd0;
            shreg        <= 24'd0;
        end else begin
            state    <= state_next;
            imem_we  <= 1'b0;
            // Status outputs follow the next state so they appear one cycle after the deciding edge.
            in_ready <= (state_next != DONE) && (state_next != ERR);
            done     <= (state_next == DONE);
            error    <= (state_next == ERR);
            cpu_hold <= (state_next != DONE);
            if (accept) begin
                case (state)
                    IDLE: chk <= 8'd0;
                    CNT_HI: begin
                        count[15:8] <= in_data;
                        chk         <= chk ^ in_data;
                    end
                    CNT_LO: begin
                        count[7:0] <= in_data;
                        chk        <= chk ^ in_data;
                        byte_idx   <= 2'd0;
                        word_idx   <= 16'd0;
                    end
                    DATA: begin
                        chk      <= chk ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: shreg[23:16] <= in_data;
                            2'd1: shreg[15:8]  <= in_data;
                            2'd2: shreg[7:0]   <= in_data;
                            default: begin
                                imem_we      <= 1'b1;
                                imem_wdata   <= {shreg, in_data};
                                imem_addr    <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                                words_loaded <= words_loaded + 16'd1;
                                word_idx     <= word_idx + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: frame driver, write scoreboard and status checks.
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;
    logic [2:0]  state;

    int tests_run = 0;
    int fail_cnt  = 0;
    int writes_seen = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  good_frame[11];

    program_loader #(
        .MAX_WORDS(18),
        .BASE_ADDR(32'h0000_0000),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error),
        .words_loaded(words_loaded),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected (addr, data) pair.
    always @(negedge clk) begin
        if (reset && imem_we) begin
            writes_seen++;
            if (exp_q.size() == 0)
                check("write_expected", 64'(exp_q.size()), 64'd1);
            else
                check("imem_write", {imem_addr, imem_wdata}, exp_q.pop_front());
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_imem_we"}, 64'(imem_we), 64'd0);
        check({tag, "_imem_addr"}, 64'(imem_addr), 64'h0);
        check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'h0);
        check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
        check({tag, "_words"}, 64'(words_loaded), 64'd0);
        check({tag, "_state"}, 64'(state), 64'd0);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values(tag);
        reset = 1'b1;
        @(negedge clk);
        check({tag, "_ready_after_rst"}, 64'(in_ready), 64'd1);
        writes_seen = 0;
    endtask

    // Presents a byte at a negedge and holds it until accepted; optional idle gap afterwards.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(waited), 64'd0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
    endtask

    task automatic send_good(input int gap, input logic [7:0] chk);
        exp_q.push_back({32'h0000_0000, 32'h2008_0005});
        exp_q.push_back({32'h0000_0004, 32'h2009_000A});
        for (int i = 0; i < 11; i++) send_byte(good_frame[i], gap);
        send_byte(chk, gap);
        in_valid = 1'b0;
    endtask

    initial begin
        good_frame = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                       8'h20, 8'h09, 8'h00, 8'h0A};
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Good back-to-back load.
        apply_reset("rst1");
        send_good(0, 8'h0C);
        check("good_done", 64'(done), 64'd1);
        check("good_hold", 64'(cpu_hold), 64'd0);
        check("good_error", 64'(error), 64'd0);
        check("good_words", 64'(words_loaded), 64'd2);
        check("good_ready", 64'(in_ready), 64'd0);
        repeat (3) @(negedge clk);
        check("good_done_sticky", 64'(done), 64'd1);
        check("good_writes", 64'(writes_seen), 64'd2);
        check("good_q_empty", 64'(exp_q.size()), 64'd0);

        // Bad checksum.
        apply_reset("rst2");
        send_good(0, 8'h0D);
        check("badchk_error", 64'(error), 64'd1);
        check("badchk_done", 64'(done), 64'd0);
        check("badchk_hold", 64'(cpu_hold), 64'd1);
        check("badchk_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("badchk_error_sticky", 64'(error), 64'd1);
        check("badchk_ready_hold", 64'(in_ready), 64'd0);
        check("badchk_writes", 64'(writes_seen), 64'd2);
        check("badchk_q_empty", 64'(exp_q.size()), 64'd0);

        // Leading junk with throttled input.
        apply_reset("rst3");
        send_byte(8'h00, 2);
        send_byte(8'hFF, 2);
        send_byte(8'h3C, 2);
        check("junk_state_idle", 64'(state), 64'd0);
        send_good(2, 8'h0C);
        check("throttle_done", 64'(done), 64'd1);
        check("throttle_hold", 64'(cpu_hold), 64'd0);
        check("throttle_words", 64'(words_loaded), 64'd2);
        check("throttle_writes", 64'(writes_seen), 64'd2);
        check("throttle_q_empty", 64'(exp_q.size()), 64'd0);

        // Oversize count.
        apply_reset("rst4");
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        in_valid = 1'b0;
        check("oversize_error", 64'(error), 64'd1);
        check("oversize_done", 64'(done), 64'd0);
        check("oversize_ready", 64'(in_ready), 64'd0);
        repeat (3) @(negedge clk);
        check("oversize_writes", 64'(writes_seen), 64'd0);

        // Maximum count accepted (18): just confirm it does not error.
        apply_reset("rst5");
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        in_valid = 1'b0;
        check("maxcount_no_error", 64'(error), 64'd0);
        check("maxcount_ready", 64'(in_ready), 64'd1);

        // Empty image.
        apply_reset("rst6");
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        in_valid = 1'b0;
        check("empty_done", 64'(done), 64'd1);
        check("empty_hold", 64'(cpu_hold), 64'd0);
        check("empty_words", 64'(words_loaded), 64'd0);
        check("empty_error", 64'(error), 64'd0);
        repeat (2) @(negedge clk);
        check("empty_writes", 64'(writes_seen), 64'd0);

        // Asynchronous reset mid-frame, then reload.
        apply_reset("rst7");
        for (int i = 0; i < 5; i++) send_byte(good_frame[i], 0);
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_reset_values("async");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("async_ready_back", 64'(in_ready), 64'd1);
        writes_seen = 0;
        send_good(0, 8'h0C);
        check("reload_done", 64'(done), 64'd1);
        check("reload_hold", 64'(cpu_hold), 64'd0);
        check("reload_words", 64'(words_loaded), 64'd2);
        repeat (2) @(negedge clk);
        check("reload_writes", 64'(writes_seen), 64'd2);
        check("reload_q_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
